// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio sample pacing path.
package audio_pkg;

  // Source of the sample presented on each audio tick.
  typedef enum logic [1:0] {
    AUD_FIFO = 2'd0,
    AUD_MUTE = 2'd1,
    AUD_SAW  = 2'd2,
    AUD_RSVD = 2'd3
  } mode_e;

  // Phase accumulator width: one bit of headroom above the modulus so that
  // acc + increment never overflows before the wrap compare.
  function automatic int nco_width(input int clk_hz);
    return $clog2(clk_hz) + 1;
  endfunction

endpackage

// File: rtl/audio_nco.sv
// Fractional (phase-accumulator) divider: emits a 1-cycle tick at an exact
// average rate of SAMPLE_HZ/CLK_HZ per enabled cycle, plus a ~50 % duty clock
// whose falling edge lands on the tick cycle.
module audio_nco
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 74_250_000,
  parameter int SAMPLE_HZ = 48_000
) (
  input  logic clk_pixel,
  input  logic reset_n,
  input  logic enable,
  output logic tick,
  output logic clk_out
);

  localparam int ACC_W = nco_width(CLK_HZ);
  localparam logic [ACC_W-1:0] INC_C  = ACC_W'(SAMPLE_HZ);
  localparam logic [ACC_W-1:0] MOD_C  = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] HALF_C = ACC_W'(CLK_HZ / 2);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] sum_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             wrap_s;
  logic             tick_r;
  logic             clk_out_r;

  // Next accumulator value: subtract the modulus exactly once on wrap so no
  // phase error is ever discarded.
  always_comb begin
    sum_s = acc_r + INC_C;
    if (sum_s >= MOD_C) begin
      wrap_s     = 1'b1;
      acc_next_s = sum_s - MOD_C;
    end else begin
      wrap_s     = 1'b0;
      acc_next_s = sum_s;
    end
  end

  // Accumulator, tick and clock register; all three freeze while disabled so
  // the phase resumes exactly where it stopped.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acc_r     <= '0;
      tick_r    <= 1'b0;
      clk_out_r <= 1'b0;
    end else if (enable) begin
      acc_r     <= acc_next_s;
      tick_r    <= wrap_s;
      clk_out_r <= (acc_next_s >= HALF_C);
    end
  end

  assign tick    = tick_r;
  assign clk_out = clk_out_r;

endmodule

// File: rtl/audio_sample_pacer.sv
// Paces HDMI audio samples from clk_pixel: one sample per NCO tick, taken
// from a show-ahead FIFO, muted, or from per-channel test sawtooths, with
// saturating underrun accounting.
module audio_sample_pacer
  import audio_pkg::*;
#(
  parameter int CLK_HZ      = 74_250_000,
  parameter int SAMPLE_HZ   = 48_000,
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_BITS = 16,
  parameter int HOLD_LAST   = 1,
  parameter int UCNT_BITS   = 16
) (
  input  logic                                  clk_pixel,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [1:0]                            mode,
  input  logic                                  clear_underrun,
  input  logic [CHANNELS*SAMPLE_BITS-1:0]       fifo_q,
  input  logic                                  fifo_empty,
  output logic                                  fifo_rd,
  output logic                                  clk_audio,
  output logic                                  sample_strobe,
  output logic [CHANNELS-1:0][SAMPLE_BITS-1:0]  audio_sample_word,
  output logic [UCNT_BITS-1:0]                  underrun_count,
  output logic                                  underrun_flag
);

  localparam bit HOLD_C = (HOLD_LAST != 0);

  logic                                 tick_s;
  logic                                 clk_audio_s;
  logic                                 take_s;
  logic                                 starve_s;
  mode_e                                mode_s;
  logic [CHANNELS-1:0][SAMPLE_BITS-1:0] saw_r;
  logic [CHANNELS-1:0][SAMPLE_BITS-1:0] saw_next_s;

  audio_nco #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ)
  ) u_nco (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .enable    (enable),
    .tick      (tick_s),
    .clk_out   (clk_audio_s)
  );

  // clk_audio is already a flop inside the NCO.
  assign clk_audio = clk_audio_s;

  // Tick qualification and underrun detection; mode is only looked at on a
  // tick, so a mid-period mode change lands on the next sample boundary.
  always_comb begin
    mode_s   = mode_e'(mode);
    take_s   = enable & tick_s;
    starve_s = take_s & (mode_s == AUD_FIFO) & fifo_empty;
  end

  // Next sawtooth values: channel c steps by 2^(c+4), wrapping naturally.
  always_comb begin
    saw_next_s = saw_r;
    for (int c = 0; c < CHANNELS; c++) begin
      saw_next_s[c] = saw_r[c] + (SAMPLE_BITS'(1) << (c + 4));
    end
  end

  // Sample register, strobe and pop: updated only in the cycle after a tick,
  // so the whole word changes at once and at most one pop per period occurs.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      audio_sample_word <= '0;
      sample_strobe     <= 1'b0;
      fifo_rd           <= 1'b0;
      saw_r             <= '0;
    end else begin
      sample_strobe <= 1'b0;
      fifo_rd       <= 1'b0;
      if (take_s) begin
        sample_strobe <= 1'b1;
        case (mode_s)
          AUD_FIFO: begin
            if (!fifo_empty) begin
              audio_sample_word <= fifo_q;
              fifo_rd           <= 1'b1;
            end else if (!HOLD_C) begin
              audio_sample_word <= '0;
            end
          end
          AUD_SAW: begin
            saw_r             <= saw_next_s;
            audio_sample_word <= saw_next_s;
          end
          default: begin
            // Mute (and the reserved code): keep draining so FIFO latency
            // stays bounded when audio is unmuted again.
            audio_sample_word <= '0;
            fifo_rd           <= ~fifo_empty;
          end
        endcase
      end
    end
  end

  // Underrun counter and sticky flag; a clear in the same cycle as a starved
  // tick wins and that tick is not counted.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      underrun_count <= '0;
      underrun_flag  <= 1'b0;
    end else if (clear_underrun) begin
      underrun_count <= '0;
      underrun_flag  <= 1'b0;
    end else if (starve_s) begin
      underrun_flag <= 1'b1;
      if (underrun_count != '1) begin
        underrun_count <= underrun_count + UCNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer with CLK_HZ=1000, SAMPLE_HZ=48.
// dut_a: HOLD_LAST=1, 16-bit counter; dut_b: HOLD_LAST=0, 4-bit counter.
// Both see identical stimulus; the FIFO model is popped by dut_a.
module tb_audio_sample_pacer;

  logic             clk_pixel = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [1:0]       mode;
  logic             clear_underrun;
  logic [31:0]      fifo_q;
  logic             fifo_empty;

  logic             rd_a, clk_a, stb_a, flag_a;
  logic [1:0][15:0] word_a;
  logic [15:0]      cnt_a;
  logic             rd_b, clk_b, stb_b, flag_b;
  logic [1:0][15:0] word_b;
  logic [3:0]       cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk_pixel = ~clk_pixel;

  audio_sample_pacer #(
    .CLK_HZ(1000), .SAMPLE_HZ(48), .CHANNELS(2), .SAMPLE_BITS(16),
    .HOLD_LAST(1), .UCNT_BITS(16)
  ) dut_a (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .enable(enable), .mode(mode),
    .clear_underrun(clear_underrun), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rd(rd_a), .clk_audio(clk_a), .sample_strobe(stb_a),
    .audio_sample_word(word_a), .underrun_count(cnt_a), .underrun_flag(flag_a)
  );

  audio_sample_pacer #(
    .CLK_HZ(1000), .SAMPLE_HZ(48), .CHANNELS(2), .SAMPLE_BITS(16),
    .HOLD_LAST(0), .UCNT_BITS(4)
  ) dut_b (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .enable(enable), .mode(mode),
    .clear_underrun(clear_underrun), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rd(rd_b), .clk_audio(clk_b), .sample_strobe(stb_b),
    .audio_sample_word(word_b), .underrun_count(cnt_b), .underrun_flag(flag_b)
  );

  // Show-ahead FIFO model
  logic [31:0] fmem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          level;

  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (level == 0);
  assign fifo_q     = fmem[rd_ptr[3:0]];

  // FIFO pop on the clock edge that ends a fifo_rd cycle
  always @(posedge clk_pixel) begin
    if (rd_a) rd_ptr <= rd_ptr + 1;
  end

  task automatic push(input logic [31:0] w);
    fmem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Monitor: strobe/pop counters, inter-strobe gaps, clk_audio fall vs strobe
  int stb_cnt = 0, rd_cnt = 0, cyc = 0, last_stb = 0;
  int gmin = 1000000, gmax = 0, fall_bad = 0;
  bit have_last = 1'b0, prev_clk = 1'b0, fall_pend = 1'b0;
  bit stats_on = 1'b0;

  always @(negedge clk_pixel) begin
    cyc       <= cyc + 1;
    prev_clk  <= clk_a;
    fall_pend <= prev_clk & ~clk_a;
    if (stb_a) stb_cnt <= stb_cnt + 1;
    if (rd_a)  rd_cnt  <= rd_cnt + 1;
    if (!stats_on) begin
      have_last <= 1'b0;
      gmin      <= 1000000;
      gmax      <= 0;
      fall_bad  <= 0;
    end else begin
      if (fall_pend && !stb_a) fall_bad <= fall_bad + 1;
      if (stb_a) begin
        if (have_last) begin
          if (cyc - last_stb < gmin) gmin <= cyc - last_stb;
          if (cyc - last_stb > gmax) gmax <= cyc - last_stb;
        end
        last_stb  <= cyc;
        have_last <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (stb_a !== 1'b1 && n < 100);
    chk(tag, stb_a, 1'b1);
  endtask

  int s0, r0;

  initial begin
    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; clear_underrun = 1'b0;
    push(32'h0001_0002); push(32'h0003_0004); push(32'h0005_0006);
    repeat (3) @(negedge clk_pixel);
    chk("rst_strobe", stb_a, 1'b0);
    chk("rst_word", word_a, 32'h0);
    chk("rst_rd", rd_a, 1'b0);
    chk("rst_clk", clk_a, 1'b0);
    chk("rst_cnt", cnt_a, 16'h0);
    chk("rst_flag", flag_a, 1'b0);

    // First tick after release comes after ceil(1000/48)=21 cycles
    reset_n = 1'b1; enable = 1'b1;
    repeat (21) @(negedge clk_pixel);
    chk("first_strobe_early", stb_a, 1'b0);
    @(negedge clk_pixel);
    chk("first_strobe", stb_a, 1'b1);
    chk("fifo_w1", word_a, 32'h0001_0002);
    chk("fifo_rd1", rd_a, 1'b1);
    chk("clk_fell_at_tick", clk_a, 1'b0);
    wait_strobe("strobe_w2");
    chk("fifo_w2", word_a, 32'h0003_0004);
    wait_strobe("strobe_w3");
    chk("fifo_w3", word_a, 32'h0005_0006);
    chk("fifo_w3_b", word_b, 32'h0005_0006);
    chk("rd_b_match", rd_b, 1'b1);
    @(negedge clk_pixel); #1;
    chk("rd_total", rd_cnt, 3);
    chk("fifo_drained", level, 0);

    // Five starved periods
    for (int i = 0; i < 5; i++) wait_strobe("strobe_starve5");
    chk("hold_last_word", word_a, 32'h0005_0006);
    chk("zero_word_b", word_b, 32'h0);
    chk("starve_rd", rd_a, 1'b0);
    chk("ucnt5_a", cnt_a, 16'd5);
    chk("ucnt5_b", cnt_b, 4'd5);
    chk("uflag_a", flag_a, 1'b1);
    chk("uflag_b", flag_b, 1'b1);
    @(negedge clk_pixel) clear_underrun = 1'b1;
    @(negedge clk_pixel) clear_underrun = 1'b0;
    chk("clear_cnt", cnt_a, 16'd0);
    chk("clear_flag", flag_a, 1'b0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) wait_strobe("strobe_starve20");
    chk("ucnt20_a", cnt_a, 16'd20);
    chk("ucnt_sat_b", cnt_b, 4'd15);
    chk("uflag_sat_b", flag_b, 1'b1);

    // Clear held across a starved tick: clear wins
    clear_underrun = 1'b1;
    wait_strobe("strobe_clear_wins");
    @(negedge clk_pixel);
    chk("clear_wins_cnt", cnt_a, 16'd0);
    chk("clear_wins_flag", flag_a, 1'b0);
    clear_underrun = 1'b0;
    mode = 2'd1;

    // NCO rate over 10000 cycles (mute, empty FIFO)
    #1 stats_on = 1'b1; s0 = stb_cnt;
    repeat (10000) @(negedge clk_pixel);
    #1;
    chk("nco_strobes", stb_cnt - s0, 480);
    chk("gap_min", gmin, 20);
    chk("gap_max", gmax, 21);
    chk("clk_fall_on_tick", fall_bad, 0);
    chk("mute_empty_no_flag", flag_a, 1'b0);
    chk("mute_empty_no_cnt", cnt_a, 16'd0);
    stats_on = 1'b0;

    // Saw mode, switched mid-period; queued word must not be popped
    wait_strobe("strobe_pre_saw");
    mode = 2'd2;
    push(32'hAAAA_5555);
    repeat (3) @(negedge clk_pixel);
    chk("saw_not_early", word_a, 32'h0);
    for (int i = 0; i < 4; i++) wait_strobe("strobe_saw");
    chk("saw_word", word_a, 32'h0080_0040);
    chk("saw_word_b", word_b, 32'h0080_0040);
    chk("saw_no_pop", level, 1);

    // Mute drains queued data without flagging
    mode = 2'd1;
    push(32'hBBBB_6666);
    wait_strobe("strobe_mute1");
    chk("mute_word", word_a, 32'h0);
    chk("mute_pop1", rd_a, 1'b1);
    wait_strobe("strobe_mute2");
    chk("mute_pop2", rd_a, 1'b1);
    @(negedge clk_pixel); #1;
    chk("mute_drained", level, 0);
    wait_strobe("strobe_mute3");
    chk("mute_empty_rd", rd_a, 1'b0);
    chk("mute_flag", flag_a, 1'b0);

    // Mode switch to FIFO mid-period applies at next tick only
    mode = 2'd0;
    push(32'h1111_2222);
    repeat (3) @(negedge clk_pixel);
    chk("switch_not_early", word_a, 32'h0);
    chk("switch_no_pop", level, 1);
    wait_strobe("strobe_switch");
    chk("switch_word", word_a, 32'h1111_2222);

    // Async reset during a pop cycle
    push(32'h3333_4444);
    wait_strobe("strobe_pop");
    chk("pop_before_reset", rd_a, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_strobe", stb_a, 1'b0);
    chk("arst_rd", rd_a, 1'b0);
    chk("arst_word", word_a, 32'h0);
    chk("arst_word_b", word_b, 32'h0);
    r0 = rd_cnt;
    repeat (5) @(negedge clk_pixel);
    #1;
    chk("arst_no_rd", rd_cnt, r0);
    chk("arst_no_pop", level, 1);

    // Release, freeze for 100 cycles mid-period, resume phase
    @(negedge clk_pixel) reset_n = 1'b1;
    repeat (11) @(negedge clk_pixel);
    chk("clk_high_c11", clk_a, 1'b1);
    enable = 1'b0;
    s0 = stb_cnt;
    repeat (100) @(negedge clk_pixel);
    #1;
    chk("frozen_no_strobe", stb_cnt, s0);
    chk("frozen_clk", clk_a, 1'b1);
    chk("frozen_no_rd", rd_cnt, r0);
    enable = 1'b1;
    repeat (10) @(negedge clk_pixel);
    chk("resume_not_early", stb_a, 1'b0);
    @(negedge clk_pixel);
    chk("resume_strobe", stb_a, 1'b1);
    chk("resume_word", word_a, 32'h3333_4444);
    chk("resume_clk_low", clk_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
